// File: rtl/cont_nbits_updown_mod.sv
// N-bit modulo-M up/down counter with sync load, cascade TC and sticky wrap.
// Define CONT_SATURATE_EN to saturate at the limits instead of wrapping.
`timescale 1ns/1ps
module cont_nbits_updown_mod #(
   parameter int WIDTH  = 4,
   parameter int MODULO = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             enable,
   input  logic             up_down,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   input  logic             clr_wrap,
   output logic [WIDTH-1:0] Q,
   output logic             TC,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULO - 1);
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic             at_top;
   logic             at_bot;
   logic             hit;
   logic [WIDTH-1:0] q_next;
   logic [WIDTH-1:0] d_clamp;

   assign at_top  = (Q == TOP);
   assign at_bot  = (Q == '0);
   assign hit     = up_down ? at_top : at_bot;
   assign TC      = enable & hit;
   assign d_clamp = (d > TOP) ? TOP : d;

   always_comb begin
      q_next = Q;
`ifdef CONT_SATURATE_EN
      if (!hit)
         q_next = up_down ? Q + ONE : Q - ONE;
`else
      if (up_down)
         q_next = at_top ? '0 : Q + ONE;
      else
         q_next = at_bot ? TOP : Q - ONE;
`endif
   end

   // a load on the limit edge suppresses the wrap flag
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         Q    <= '0;
         wrap <= 1'b0;
      end else begin
         if (load)
            Q <= d_clamp;
         else if (enable)
            Q <= q_next;
         if (TC && !load)
            wrap <= 1'b1;
         else if (clr_wrap)
            wrap <= 1'b0;
      end
   end

endmodule

// File: tb/tb_cont_nbits_updown_mod.sv
// Bench for cont_nbits_updown_mod (WIDTH=4, MODULO=10) against a spec-level
// model; directed scenarios, random stimulus and a two-stage cascade.
`timescale 1ns/1ps
module tb_cont_nbits_updown_mod;

   localparam int W = 4;
   localparam int M = 10;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         reset_n;
   logic         enable;
   logic         up_down;
   logic         load;
   logic         clr_wrap;
   logic [W-1:0] d;
   logic [W-1:0] q;
   logic         tc;
   logic         wrap;

   logic         c_en;
   logic [W-1:0] lo_q;
   logic [W-1:0] hi_q;
   logic         lo_tc;
   logic         hi_tc;
   logic         lo_wrap;
   logic         hi_wrap;

   int vectors     = 0;
   int miscompares = 0;

   int mq = 0;
   bit mw = 1'b0;

   cont_nbits_updown_mod #(.WIDTH(W), .MODULO(M)) dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .up_down(up_down),
      .load(load), .d(d), .clr_wrap(clr_wrap),
      .Q(q), .TC(tc), .wrap(wrap)
   );

   cont_nbits_updown_mod #(.WIDTH(W), .MODULO(M)) c_lo (
      .clk(clk), .reset_n(reset_n), .enable(c_en), .up_down(1'b1),
      .load(1'b0), .d('0), .clr_wrap(1'b0),
      .Q(lo_q), .TC(lo_tc), .wrap(lo_wrap)
   );

   cont_nbits_updown_mod #(.WIDTH(W), .MODULO(M)) c_hi (
      .clk(clk), .reset_n(reset_n), .enable(lo_tc), .up_down(1'b1),
      .load(1'b0), .d('0), .clr_wrap(1'b0),
      .Q(hi_q), .TC(hi_tc), .wrap(hi_wrap)
   );

   function automatic bit at_lim(int v, bit up);
      return up ? (v == M - 1) : (v == 0);
   endfunction

   function automatic int nxt(int v, bit up);
`ifdef CONT_SATURATE_EN
      if (at_lim(v, up)) return v;
      return up ? v + 1 : v - 1;
`else
      return up ? (v + 1) % M : (v + M - 1) % M;
`endif
   endfunction

   // advance the model from the inputs present now, then take one edge
   task automatic tick();
      bit wr;
      if (!reset_n) begin
         mq = 0;
         mw = 1'b0;
      end else begin
         wr = !load && enable && at_lim(mq, up_down);
         if (load)
            mq = (int'(d) > M - 1) ? M - 1 : int'(d);
         else if (enable)
            mq = nxt(mq, up_down);
         if (wr) mw = 1'b1;
         else if (clr_wrap) mw = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b1; load = 1'b1; d = 4'd7; enable = 1'b0;
      tick();
      vectors++;
      if (q !== 4'd7) begin
         miscompares++;
         $display("FAIL reset_preload q=%0d want 7", q);
      end
      reset_n = 1'b0; load = 1'b0; enable = 1'b1; up_down = 1'b1;
      tick();
      enable = 1'b0;
      #1;
      vectors++;
      if (q !== 4'd0 || wrap !== 1'b0 || tc !== 1'b0) begin
         miscompares++;
         $display("FAIL reset q=%0d wrap=%0b tc=%0b want 0 0 0", q, wrap, tc);
      end
   endtask

   task automatic test_up();
      reset_n = 1'b1; enable = 1'b1; up_down = 1'b1; load = 1'b0;
      for (int i = 1; i <= 12; i++) begin
         tick();
         vectors++;
         if (q !== 4'(mq) || wrap !== mw || tc !== (q == 4'd9)) begin
            miscompares++;
            $display("FAIL up edge %0d q=%0d wrap=%0b tc=%0b want %0d %0b %0b",
                     i, q, wrap, tc, mq, mw, (mq == 9));
         end
`ifndef CONT_SATURATE_EN
         vectors++;
         if (q !== 4'(i % M) || wrap !== (i >= M)) begin
            miscompares++;
            $display("FAIL up_const edge %0d q=%0d wrap=%0b want %0d %0b",
                     i, q, wrap, i % M, (i >= M));
         end
`endif
      end
      enable = 1'b0; clr_wrap = 1'b1;
      tick();
      clr_wrap = 1'b0;
      vectors++;
      if (wrap !== 1'b0 || q !== 4'(mq)) begin
         miscompares++;
         $display("FAIL clr_wrap wrap=%0b q=%0d want 0 %0d", wrap, q, mq);
      end
   endtask

   task automatic test_down();
      int exp_q[3] = '{0, 9, 8};
      load = 1'b1; d = 4'd1; enable = 1'b0;
      tick();
      load = 1'b0; enable = 1'b1; up_down = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         vectors++;
         if (tc !== (enable && at_lim(mq, up_down))) begin
            miscompares++;
            $display("FAIL down_tc step %0d tc=%0b q=%0d", i, tc, q);
         end
         tick();
         vectors++;
         if (q !== 4'(mq) || wrap !== mw) begin
            miscompares++;
            $display("FAIL down step %0d q=%0d wrap=%0b want %0d %0b",
                     i, q, wrap, mq, mw);
         end
`ifndef CONT_SATURATE_EN
         vectors++;
         if (q !== 4'(exp_q[i])) begin
            miscompares++;
            $display("FAIL down_const step %0d q=%0d want %0d", i, q, exp_q[i]);
         end
`endif
      end
   endtask

   task automatic test_load();
      enable = 1'b1; up_down = 1'b1; load = 1'b1; d = 4'd5; clr_wrap = 1'b1;
      tick();
      clr_wrap = 1'b0;
      vectors++;
      if (q !== 4'd5 || wrap !== 1'b0) begin
         miscompares++;
         $display("FAIL load5 q=%0d wrap=%0b want 5 0", q, wrap);
      end
      d = 4'd13;
      tick();
      vectors++;
      if (q !== 4'd9) begin
         miscompares++;
         $display("FAIL load_clamp q=%0d want 9", q);
      end
      // TC is high here, but the load must win and leave wrap clear
      d = 4'd9;
      #1;
      vectors++;
      if (tc !== 1'b1) begin
         miscompares++;
         $display("FAIL load_tc tc=%0b want 1", tc);
      end
      tick();
      vectors++;
      if (q !== 4'd9 || wrap !== 1'b0) begin
         miscompares++;
         $display("FAIL load_nowrap q=%0d wrap=%0b want 9 0", q, wrap);
      end
      reset_n = 1'b0; d = 4'd6;
      tick();
      reset_n = 1'b1; load = 1'b0;
      vectors++;
      if (q !== 4'd0) begin
         miscompares++;
         $display("FAIL load_reset q=%0d want 0", q);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         reset_n  = ($urandom % 25) != 0;
         load     = ($urandom % 7) == 0;
         enable   = ($urandom % 4) != 0;
         up_down  = ($urandom % 2) != 0;
         clr_wrap = ($urandom % 9) == 0;
         d        = 4'($urandom_range(0, 15));
         #1;
         vectors++;
         if (tc !== (enable && at_lim(mq, up_down))) begin
            miscompares++;
            $display("FAIL rand_tc cyc %0d tc=%0b q=%0d en=%0b up=%0b",
                     i, tc, q, enable, up_down);
         end
         tick();
         vectors++;
         if (q !== 4'(mq) || wrap !== mw) begin
            miscompares++;
            $display("FAIL rand cyc %0d q=%0d wrap=%0b want %0d %0b",
                     i, q, wrap, mq, mw);
         end
      end
      reset_n = 1'b1; load = 1'b0; clr_wrap = 1'b0; enable = 1'b0;
   endtask

   task automatic test_cascade();
      int lo_m = 0;
      int hi_m = 0;
      bit lw = 1'b0;
      bit hw = 1'b0;
      reset_n = 1'b0; enable = 1'b0; load = 1'b0;
      tick();
      reset_n = 1'b1; c_en = 1'b1;
      for (int k = 1; k <= 100; k++) begin
         if (lo_m == M - 1) begin
            if (hi_m == M - 1) hw = 1'b1;
            hi_m = nxt(hi_m, 1'b1);
            lw = 1'b1;
         end
         lo_m = nxt(lo_m, 1'b1);
         tick();
         vectors++;
         if (lo_q !== 4'(lo_m) || hi_q !== 4'(hi_m) ||
             lo_wrap !== lw || hi_wrap !== hw) begin
            miscompares++;
            $display("FAIL cascade edge %0d lo=%0d hi=%0d hw=%0b want %0d %0d %0b",
                     k, lo_q, hi_q, hi_wrap, lo_m, hi_m, hw);
         end
      end
`ifndef CONT_SATURATE_EN
      vectors++;
      if (lo_q !== 4'd0 || hi_q !== 4'd0 || hi_wrap !== 1'b1) begin
         miscompares++;
         $display("FAIL cascade_100 lo=%0d hi=%0d hw=%0b want 0 0 1",
                  lo_q, hi_q, hi_wrap);
      end
`endif
      c_en = 1'b0;
   endtask

`ifdef CONT_SATURATE_EN
   task automatic test_saturate();
      logic [W-1:0] eq[3] = '{4'd9, 4'd9, 4'd9};
      bit           ew[3] = '{1'b0, 1'b1, 1'b1};
      load = 1'b1; d = 4'd8; enable = 1'b0; clr_wrap = 1'b1;
      tick();
      load = 1'b0; clr_wrap = 1'b0; enable = 1'b1; up_down = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         vectors++;
         if (q !== eq[i] || wrap !== ew[i]) begin
            miscompares++;
            $display("FAIL sat_up edge %0d q=%0d wrap=%0b want %0d %0b",
                     i + 1, q, wrap, eq[i], ew[i]);
         end
      end
      load = 1'b1; d = 4'd0; enable = 1'b0; clr_wrap = 1'b1;
      tick();
      load = 1'b0; clr_wrap = 1'b0; enable = 1'b1; up_down = 1'b0;
      tick();
      vectors++;
      if (q !== 4'd0 || wrap !== 1'b1) begin
         miscompares++;
         $display("FAIL sat_down q=%0d wrap=%0b want 0 1", q, wrap);
      end
      enable = 1'b0;
   endtask
`endif

   initial begin
      reset_n = 1'b0; enable = 1'b0; up_down = 1'b1; load = 1'b0;
      clr_wrap = 1'b0; d = '0; c_en = 1'b0;
      tick();
      tick();
      test_reset();
      test_up();
      test_down();
      test_load();
`ifdef CONT_SATURATE_EN
      test_saturate();
`endif
      test_random();
      test_cascade();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
